// File: rtl/alu_arb_pkg.sv
// Types and constants for the two-requester alu arbiter.
package alu_arb_pkg;

  localparam int ARB_NREQ = 2;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_EXEC,
    ARB_RESP
  } alu_arb_state_t;

  typedef struct packed {
    logic overflow;
    logic zero;
    logic equal;
  } alu_flags_t;

  function automatic logic [ARB_NREQ-1:0] arb_onehot(input logic idx);
    arb_onehot      = '0;
    arb_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/alu_types.sv
// Operation encodings shared by the alu and everything that drives it.
package alu_types;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10
  } alu_control_t;

endpackage

// File: rtl/alu.sv
// Combinational N-bit alu with signed overflow, zero and operand-equality flags.
module alu
  import alu_types::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0]  a_i,
  input  logic [N-1:0]  b_i,
  input  alu_control_t  control_i,
  output logic [N-1:0]  result_o,
  output logic          overflow_o,
  output logic          zero_o,
  output logic          equal_o
);

  localparam int SW = $clog2(N);

  logic          sub_sel;
  logic [N-1:0]  b_eff;
  logic [N-1:0]  sum;
  logic [SW-1:0] shamt;

  // Add and subtract share one adder; subtract is a + ~b + 1.
  assign sub_sel = (control_i == ALU_SUB);
  assign b_eff   = sub_sel ? ~b_i : b_i;
  assign sum     = a_i + b_eff + N'(sub_sel);
  assign shamt   = b_i[SW-1:0];

  always_comb begin
    result_o   = '0;
    overflow_o = 1'b0;
    case (control_i)
      ALU_ADD, ALU_SUB: begin
        result_o   = sum;
        overflow_o = (a_i[N-1] == b_eff[N-1]) && (sum[N-1] != a_i[N-1]);
      end
      ALU_AND:  result_o = a_i & b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_NOR:  result_o = ~(a_i | b_i);
      ALU_SLT:  result_o = N'($signed(a_i) < $signed(b_i));
      ALU_SLTU: result_o = N'(a_i < b_i);
      ALU_SLL:  result_o = a_i << shamt;
      ALU_SRL:  result_o = a_i >> shamt;
      ALU_SRA:  result_o = $signed(a_i) >>> shamt;
      default:  result_o = '0;
    endcase
  end

  assign zero_o  = (result_o == '0);
  assign equal_o = (a_i == b_i);

endmodule

// File: rtl/alu_arb_pick.sv
// Grant selection between the two alu requesters.
// ALU_ARB_FIXED_PRIO_EN: requester 0 always wins a tie; otherwise round-robin on last_grant.
module alu_arb_pick
  import alu_arb_pkg::*;
(
  input  logic [ARB_NREQ-1:0] req_valid_i,
  input  logic                last_grant_i,
  output logic                grant_o,
  output logic                any_valid_o
);

  assign any_valid_o = |req_valid_i;

`ifdef ALU_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;
  assign grant_o           = ~req_valid_i[0];
`else
  // A tie goes to whoever was not served last; a lone requester simply wins.
  assign grant_o = (&req_valid_i) ? ~last_grant_i : ~req_valid_i[0];
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one alu between two valid/ready requesters, one operation in flight at a time.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority to requester 0 instead of round-robin.
module alu_arbiter
  import alu_types::*;
  import alu_arb_pkg::*;
#(
  parameter int N = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ARB_NREQ-1:0]          req_valid,
  output logic [ARB_NREQ-1:0]          req_ready,
  input  logic [ARB_NREQ-1:0][N-1:0]   req_a,
  input  logic [ARB_NREQ-1:0][N-1:0]   req_b,
  input  alu_control_t [ARB_NREQ-1:0]  req_control,
  output logic [ARB_NREQ-1:0]          rsp_valid,
  input  logic [ARB_NREQ-1:0]          rsp_ready,
  output logic [N-1:0]                 rsp_result,
  output alu_flags_t                   rsp_flags
);

  alu_arb_state_t      state_q;
  logic                last_grant_q;
  logic                grant_q;
  logic [N-1:0]        op_a_q;
  logic [N-1:0]        op_b_q;
  alu_control_t        op_control_q;
  logic [ARB_NREQ-1:0] rsp_valid_q;
  logic [N-1:0]        rsp_result_q;
  alu_flags_t          rsp_flags_q;

  logic                pick_grant;
  logic                pick_any;
  logic                accept_d;
  logic [N-1:0]        alu_result;
  logic                alu_overflow;
  logic                alu_zero;
  logic                alu_equal;

  alu_arb_pick u_pick (
    .req_valid_i  (req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (pick_grant),
    .any_valid_o  (pick_any)
  );

  // Acceptance only from IDLE and never while reset is held.
  assign accept_d = rst && (state_q == ARB_IDLE) && pick_any;

  generate
    for (genvar gi = 0; gi < ARB_NREQ; gi++) begin : g_ready
      assign req_ready[gi] = accept_d && (pick_grant == 1'(gi));
    end
  endgenerate

  alu #(.N(N)) u_alu (
    .a_i        (op_a_q),
    .b_i        (op_b_q),
    .control_i  (op_control_q),
    .result_o   (alu_result),
    .overflow_o (alu_overflow),
    .zero_o     (alu_zero),
    .equal_o    (alu_equal)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_control_q <= ALU_ADD;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (accept_d) begin
            op_a_q       <= req_a[pick_grant];
            op_b_q       <= req_b[pick_grant];
            op_control_q <= req_control[pick_grant];
            grant_q      <= pick_grant;
            state_q      <= ARB_EXEC;
          end
        end
        ARB_EXEC: begin
          rsp_result_q <= alu_result;
          rsp_flags_q  <= '{overflow: alu_overflow, zero: alu_zero, equal: alu_equal};
          rsp_valid_q  <= arb_onehot(grant_q);
          state_q      <= ARB_RESP;
        end
        ARB_RESP: begin
          // Only the granted channel's ready retires the response.
          if (rsp_ready[grant_q]) begin
            rsp_valid_q  <= '0;
            last_grant_q <= grant_q;
            state_q      <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;

  a_req_ready_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(req_ready));
  a_rsp_valid_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(rsp_valid_q));
  a_rsp_hold: assert property (@(posedge clk) disable iff (!rst)
    (state_q == ARB_RESP && !rsp_ready[grant_q]) |=> ($stable(rsp_result_q) && $stable(rsp_valid_q)));

endmodule
